// File: rtl/par_mbox_if.sv
// Signal bundle between the picoVersat parallel port, the mailbox and the host stream pair.
// The slave modport is the mailbox side; master is the core/host side.
interface par_mbox_if #(
    parameter int DATA_W  = 32,
    parameter int PADDR_W = 11
) ();
    logic [PADDR_W-1:0] par_addr;
    logic               par_we;
    logic [DATA_W-1:0]  par_out;
    logic [DATA_W-1:0]  par_in;
    logic [DATA_W-1:0]  host_tx_data;
    logic               host_tx_valid;
    logic               host_tx_ready;
    logic [DATA_W-1:0]  host_rx_data;
    logic               host_rx_valid;
    logic               host_rx_ready;
    logic               irq;

    modport slave (
        input  par_addr, par_we, par_out, host_tx_data, host_tx_valid, host_rx_ready,
        output par_in, host_tx_ready, host_rx_data, host_rx_valid, irq
    );

    modport master (
        output par_addr, par_we, par_out, host_tx_data, host_tx_valid, host_rx_ready,
        input  par_in, host_tx_ready, host_rx_data, host_rx_valid, irq
    );
endinterface

// File: rtl/par_mbox.sv
// Register-mapped mailbox: RX FIFO (host->core) and TX FIFO (core->host) behind the parallel port.
// Optional loopback of TX_DATA writes into the RX FIFO is built when PAR_MBOX_LOOPBACK_EN is defined.
module par_mbox #(
    parameter int DATA_W  = 32,
    parameter int PADDR_W = 11,
    parameter int FIFO_AW = 3
) (
    input  logic      clk,
    input  logic      rst,
    par_mbox_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [2:0] A_STATUS  = 3'd0;
    localparam logic [2:0] A_RX_DATA = 3'd1;
    localparam logic [2:0] A_RX_POP  = 3'd2;
    localparam logic [2:0] A_TX_DATA = 3'd3;
    localparam logic [2:0] A_CTRL    = 3'd4;
    localparam logic [2:0] A_CLR     = 3'd5;

    logic [DATA_W-1:0]  rx_mem [DEPTH];
    logic [DATA_W-1:0]  tx_mem [DEPTH];
    logic [FIFO_AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
    logic [FIFO_AW:0]   rx_cnt, tx_cnt;
    logic               rx_empty, rx_full, tx_empty, tx_full;
    logic               tx_ovf, rx_udf, ien, loop;
    logic               host_tx_rdy;
    logic [2:0]         addr;
    logic               unused_addr;
    logic               wr_rx_pop, wr_tx, wr_ctrl, wr_clr;
    logic               host_push, loop_push, rx_push, rx_pop, tx_push, tx_pop, ovf_set;
    logic [DATA_W-1:0]  rx_wdata, status, rd_mux;
    logic [DATA_W-1:0]  rd_data_p1;
    logic               irq_p1;

    // Only the low three address bits decode; the rest alias.
    assign addr        = bus.par_addr[2:0];
    assign unused_addr = ^bus.par_addr;

    assign rx_empty = (rx_cnt == '0);
    assign rx_full  = rx_cnt[FIFO_AW];
    assign tx_empty = (tx_cnt == '0);
    assign tx_full  = tx_cnt[FIFO_AW];

    assign wr_rx_pop = bus.par_we && (addr == A_RX_POP);
    assign wr_tx     = bus.par_we && (addr == A_TX_DATA);
    assign wr_ctrl   = bus.par_we && (addr == A_CTRL);
    assign wr_clr    = bus.par_we && (addr == A_CLR);

    assign host_tx_rdy = !rx_full && !loop;
    assign host_push   = bus.host_tx_valid && host_tx_rdy;
    assign loop_push   = wr_tx && loop && !rx_full;
    assign rx_push     = host_push || loop_push;
    assign rx_pop      = wr_rx_pop && !rx_empty;
    assign tx_push     = wr_tx && !loop && !tx_full;
    assign tx_pop      = !tx_empty && bus.host_rx_ready;
    assign ovf_set     = wr_tx && (loop ? rx_full : tx_full);
    assign rx_wdata    = loop_push ? bus.par_out : bus.host_tx_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
            ien    <= 1'b0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            rx_cnt <= rx_cnt + (FIFO_AW+1)'(rx_push) - (FIFO_AW+1)'(rx_pop);
            tx_cnt <= tx_cnt + (FIFO_AW+1)'(tx_push) - (FIFO_AW+1)'(tx_pop);
            if (wr_clr) begin
                tx_ovf <= 1'b0;
                rx_udf <= 1'b0;
            end else begin
                if (ovf_set)                 tx_ovf <= 1'b1;
                if (wr_rx_pop && rx_empty)   rx_udf <= 1'b1;
            end
            if (wr_ctrl) ien <= bus.par_out[0];
        end
    end

`ifdef PAR_MBOX_LOOPBACK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         loop <= 1'b0;
        else if (wr_ctrl) loop <= bus.par_out[1];
    end
`else
    assign loop = 1'b0;
`endif

    // FIFO storage is data only: pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp] <= rx_wdata;
        if (tx_push) tx_mem[tx_wp] <= bus.par_out;
    end

    always_comb begin
        status                   = '0;
        status[0]                = rx_empty;
        status[1]                = rx_full;
        status[2]                = tx_empty;
        status[3]                = tx_full;
        status[4]                = tx_ovf;
        status[5]                = rx_udf;
        status[8 +: FIFO_AW+1]  = rx_cnt;
        status[16 +: FIFO_AW+1] = tx_cnt;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            A_STATUS:  rd_mux = status;
            A_RX_DATA: rd_mux = rx_empty ? '0 : rx_mem[rx_rp];
            A_CTRL: begin
                rd_mux[0] = ien;
                rd_mux[1] = loop;
            end
            default:   rd_mux = '0;
        endcase
    end

    // Stage p1: registered read data and interrupt, one cycle behind the state they report.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_p1 <= '0;
            irq_p1     <= 1'b0;
        end else begin
            rd_data_p1 <= rd_mux;
            irq_p1     <= ien && !rx_empty;
        end
    end

    assign bus.par_in        = rd_data_p1;
    assign bus.irq           = irq_p1;
    assign bus.host_tx_ready = host_tx_rdy;
    assign bus.host_rx_valid = !tx_empty;
    assign bus.host_rx_data  = tx_empty ? '0 : tx_mem[tx_rp];
endmodule
